// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 read-side controller: FSM encoding,
// default bus timing (50 MHz iCLK) and LCD bit/register-select constants.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_EN_LO,
    ST_DONE
  } lcd_state_t;

  localparam int unsigned SETUP_CYC_DEF  = 2;
  localparam int unsigned EN_HI_CYC_DEF  = 25;
  localparam int unsigned SAMPLE_CYC_DEF = 20;
  localparam int unsigned EN_LO_CYC_DEF  = 25;
  localparam int unsigned POLL_MAX_DEF   = 1000;

  localparam int unsigned LCD_BF_BIT = 7;
  localparam logic        RS_CMD     = 1'b0;
  localparam logic        RS_DATA    = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter shared by the SETUP/EN_HI/EN_LO phases; oDONE marks the
// last cycle of a phase and oMATCH flags the sample point within EN_HI.
module lcd_phase_timer #(
  parameter int unsigned W = 5
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  input  logic         iLOAD,
  input  logic [W-1:0] iLOAD_VAL,
  input  logic [W-1:0] iMATCH_VAL,
  output logic         oDONE,
  output logic         oMATCH
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      cnt_q <= '0;
    else if (iLOAD)
      cnt_q <= iLOAD_VAL;
    else if (cnt_q != '0)
      cnt_q <= cnt_q - W'(1);
  end

  assign oDONE  = (cnt_q == '0);
  assign oMATCH = (cnt_q == iMATCH_VAL);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 8-bit read-cycle controller (busy flag/AC or DDRAM/CGRAM byte).
// Optional busy-flag polling is built only with LCD_READER_BUSY_POLL_EN defined.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
  parameter int unsigned EN_HI_CYC  = EN_HI_CYC_DEF,
  parameter int unsigned SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int unsigned EN_LO_CYC  = EN_LO_CYC_DEF,
  parameter int unsigned POLL_MAX   = POLL_MAX_DEF
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iREQ,
  input  logic       iRS,
  input  logic       iPOLL,
  output logic       oREADY,
  output logic       oVALID,
  output logic [7:0] oDATA,
  output logic       oTIMEOUT,
  input  logic [7:0] iLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oLCD_EN,
  output logic       oBUS_OWN
);

  localparam int unsigned PH_MAX = max3(SETUP_CYC, EN_HI_CYC, EN_LO_CYC);
  localparam int unsigned CNT_W  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  lcd_state_t       state_q, state_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_done;
  logic             sample_hit;
  logic             accept;
  logic             again;
  logic             rs_q;
  logic [7:0]       cap_q;

  assign accept = iREQ && oREADY;

  lcd_phase_timer #(
    .W(CNT_W)
  ) u_timer (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iLOAD     (timer_load),
    .iLOAD_VAL (timer_val),
    .iMATCH_VAL(CNT_W'(EN_HI_CYC - SAMPLE_CYC)),
    .oDONE     (timer_done),
    .oMATCH    (sample_hit)
  );

`ifdef LCD_READER_BUSY_POLL_EN
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

  logic              poll_q;
  logic [POLL_W-1:0] rd_cnt_q;

  // rd_cnt_q counts reads issued for this request, including the one in flight.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      poll_q   <= 1'b0;
      rd_cnt_q <= '0;
    end else if (accept) begin
      poll_q   <= iPOLL && (iRS == RS_CMD);
      rd_cnt_q <= POLL_W'(1);
    end else if (state_q == ST_EN_LO && timer_done && again &&
                 rd_cnt_q != POLL_W'(POLL_MAX)) begin
      rd_cnt_q <= rd_cnt_q + POLL_W'(1);
    end
  end

  assign again    = poll_q && cap_q[LCD_BF_BIT] && (rd_cnt_q < POLL_W'(POLL_MAX));
  assign oTIMEOUT = (state_q == ST_DONE) && poll_q && cap_q[LCD_BF_BIT];
`else
  logic unused_poll;
  assign unused_poll = iPOLL ^ (POLL_MAX == 0);
  assign again       = 1'b0;
  assign oTIMEOUT    = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = (state_q == ST_DONE) ? ST_IDLE : ST_IDLE;
        if (iREQ) begin
          state_d    = ST_SETUP;
          timer_load = 1'b1;
          timer_val  = CNT_W'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: if (timer_done) begin
        state_d    = ST_EN_HI;
        timer_load = 1'b1;
        timer_val  = CNT_W'(EN_HI_CYC - 1);
      end
      ST_EN_HI: if (timer_done) begin
        state_d    = ST_EN_LO;
        timer_load = 1'b1;
        timer_val  = CNT_W'(EN_LO_CYC - 1);
      end
      ST_EN_LO: if (timer_done) begin
        if (again) begin
          state_d    = ST_SETUP;
          timer_load = 1'b1;
          timer_val  = CNT_W'(SETUP_CYC - 1);
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oREADY   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    oVALID   = (state_q == ST_DONE);
    oBUS_OWN = (state_q == ST_SETUP) || (state_q == ST_EN_HI) || (state_q == ST_EN_LO);
    oLCD_RW  = oBUS_OWN;
    oLCD_RS  = oBUS_OWN && rs_q;
    oLCD_EN  = (state_q == ST_EN_HI);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rs_q  <= RS_CMD;
      cap_q <= '0;
    end else begin
      if (accept)
        rs_q <= iRS;
      if (state_q == ST_EN_HI && sample_hit)
        cap_q <= iLCD_DATA;
    end
  end

  assign oDATA = cap_q;

endmodule
